// File: rtl/hsv_sample_scheduler.sv
// Frame-level scheduler for the shared HSV converter: it captures three probe pixels per frame,
// issues them one at a time, majority-votes the detector classes and debounces the vote across frames.
module hsv_sample_scheduler #(
  parameter int ROW           = 240,
  parameter int COL_CENTRE    = 320,
  parameter int COL_OFFSET    = 64,
  parameter int STABLE_FRAMES = 4,
  parameter int TIMEOUT       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] video_data,
  input  logic        vga_ready,
  input  logic [9:0]  x_count,
  input  logic [8:0]  y_count,
  output logic [3:0]  hsv_r,
  output logic [3:0]  hsv_g,
  output logic [3:0]  hsv_b,
  output logic        hsv_valid_in,
  input  logic        hsv_valid_out,
  input  logic        is_red,
  input  logic        is_green,
  input  logic        is_black,
  output logic [1:0]  color_code,
  output logic        color_changed,
  output logic        frame_done,
  output logic        busy,
  output logic        conv_timeout,
  output logic [7:0]  drop_count,
  output logic [1:0]  dbg_state
);
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [9:0]    COL_L      = 10'(COL_CENTRE - COL_OFFSET);
  localparam logic [9:0]    COL_C      = 10'(COL_CENTRE);
  localparam logic [9:0]    COL_R      = 10'(COL_CENTRE + COL_OFFSET);
  localparam logic [8:0]    ROW_Y      = 9'(ROW);
  localparam logic [1:0]    C_NONE = 2'd0, C_RED = 2'd1, C_GREEN = 2'd2, C_BLACK = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DECIDE} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_k;
  logic [2:0]       r_cap_mask;
  logic [2:0][11:0] r_pix;
  logic [2:0][1:0]  r_votes;
  logic [TW-1:0]    r_tmo_cnt;
  logic [1:0]       r_candidate;
  logic [SW-1:0]    r_stable_cnt;
  logic [1:0]       r_color_code;
  logic             r_color_changed, r_frame_done, r_conv_timeout;
  logic [7:0]       r_drop_count;

  logic             w_frame_end, w_issue, w_probe_done, w_tmo;
  logic [1:0]       w_probe_vote, w_frame_vote;
  logic [SW-1:0]    w_stable_nxt;

  assign w_frame_end = vga_ready && (x_count == 10'd639) && (y_count == 9'd479);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Converter handshake: hsv_valid_in is a single-cycle issue strobe with no back-pressure, and
  // hsv_valid_out is accepted only in WAIT, so a stray or late result never lands in a vote.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_probe_done = 1'b0;
    w_tmo        = 1'b0;
    w_probe_vote = C_NONE;
    case (r_state)
      S_IDLE:   if (w_frame_end) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (r_cap_mask[r_k]) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_probe_done = 1'b1;
        end
      end
      S_WAIT: begin
        if (hsv_valid_out) begin
          w_probe_done = 1'b1;
          if (is_red)        w_probe_vote = C_RED;
          else if (is_green) w_probe_vote = C_GREEN;
          else if (is_black) w_probe_vote = C_BLACK;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_probe_done = 1'b1;
          w_tmo        = 1'b1;
        end
      end
      S_DECIDE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_probe_done) w_state_nxt = (r_k == 2'd2) ? S_DECIDE : S_ISSUE;
  end

  always_comb begin
    w_frame_vote = C_NONE;
    if (r_votes[0] == r_votes[1] || r_votes[0] == r_votes[2]) w_frame_vote = r_votes[0];
    else if (r_votes[1] == r_votes[2])                         w_frame_vote = r_votes[1];
    w_stable_nxt = SW'(1);
    if (w_frame_vote == r_candidate)
      w_stable_nxt = (r_stable_cnt == STABLE_MAX) ? r_stable_cnt : r_stable_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k             <= 2'd0;
      r_cap_mask      <= 3'b000;
      r_pix           <= '0;
      r_votes         <= '0;
      r_tmo_cnt       <= '0;
      r_candidate     <= C_NONE;
      r_stable_cnt    <= '0;
      r_color_code    <= C_NONE;
      r_color_changed <= 1'b0;
      r_frame_done    <= 1'b0;
      r_conv_timeout  <= 1'b0;
      r_drop_count    <= 8'd0;
    end else begin
      r_color_changed <= 1'b0;
      r_frame_done    <= 1'b0;
      if (r_state == S_IDLE && vga_ready && y_count == ROW_Y) begin
        if (x_count == COL_L) begin r_pix[0] <= video_data; r_cap_mask[0] <= 1'b1; end
        if (x_count == COL_C) begin r_pix[1] <= video_data; r_cap_mask[1] <= 1'b1; end
        if (x_count == COL_R) begin r_pix[2] <= video_data; r_cap_mask[2] <= 1'b1; end
      end
      if (r_state == S_IDLE && w_frame_end) r_k <= 2'd0;
      if (w_frame_end && r_state != S_IDLE && r_drop_count != 8'hFF)
        r_drop_count <= r_drop_count + 8'd1;
      if (w_issue)                r_tmo_cnt <= '0;
      else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_probe_done) begin
        r_votes[r_k] <= w_probe_vote;
        if (r_k != 2'd2) r_k <= r_k + 2'd1;
      end
      if (w_tmo) r_conv_timeout <= 1'b1;
      if (r_state == S_DECIDE) begin
        r_candidate  <= w_frame_vote;
        r_stable_cnt <= w_stable_nxt;
        r_frame_done <= 1'b1;
        r_cap_mask   <= 3'b000;
        if (w_stable_nxt == STABLE_MAX && w_frame_vote != r_color_code) begin
          r_color_code    <= w_frame_vote;
          r_color_changed <= 1'b1;
        end
      end
    end
  end

  assign hsv_valid_in          = w_issue;
  assign {hsv_r, hsv_g, hsv_b} = w_issue ? r_pix[r_k] : 12'h000;
  assign color_code            = r_color_code;
  assign color_changed         = r_color_changed;
  assign frame_done            = r_frame_done;
  assign busy                  = (r_state != S_IDLE);
  assign conv_timeout          = r_conv_timeout;
  assign drop_count            = r_drop_count;
  assign dbg_state             = r_state;
endmodule

// File: tb/tb_hsv_sample_scheduler.sv
// Directed bench for hsv_sample_scheduler: drives probe pixels and frame ends directly and
// answers issues from a converter stub whose latency is chosen per step.
module tb_hsv_sample_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] video_data;
  logic        vga_ready;
  logic [9:0]  x_count;
  logic [8:0]  y_count;
  logic [3:0]  hsv_r, hsv_g, hsv_b;
  logic        hsv_valid_in;
  logic        hsv_valid_out = 1'b0;
  logic        is_red = 1'b0, is_green = 1'b0, is_black = 1'b0;
  logic [1:0]  color_code;
  logic        color_changed, frame_done, busy, conv_timeout;
  logic [7:0]  drop_count;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int issue_cnt = 0;
  int stub_lat = 1;
  int stub_cnt = 0;
  logic [11:0] stub_rgb = 12'h000;

  always #5 clk = ~clk;

  hsv_sample_scheduler dut (
    .clk(clk), .reset(reset), .video_data(video_data), .vga_ready(vga_ready),
    .x_count(x_count), .y_count(y_count), .hsv_r(hsv_r), .hsv_g(hsv_g), .hsv_b(hsv_b),
    .hsv_valid_in(hsv_valid_in), .hsv_valid_out(hsv_valid_out), .is_red(is_red),
    .is_green(is_green), .is_black(is_black), .color_code(color_code),
    .color_changed(color_changed), .frame_done(frame_done), .busy(busy),
    .conv_timeout(conv_timeout), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Converter stub: answers each issue after stub_lat cycles; stub_lat==0 never answers.
  always @(negedge clk) begin
    hsv_valid_out = 1'b0;
    is_red = 1'b0; is_green = 1'b0; is_black = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        hsv_valid_out = 1'b1;
        is_red   = (stub_rgb[11:8] == 4'hF);
        is_green = (stub_rgb[7:4] == 4'hF);
        is_black = (stub_rgb == 12'h000);
      end
    end
    if (frame_done) done_cnt++;
    if (hsv_valid_in) begin
      issue_cnt++;
      check("valid_in_only_in_issue", {30'd0, dbg_state}, 32'd1);
      if (stub_lat > 0) begin
        stub_rgb = {hsv_r, hsv_g, hsv_b};
        stub_cnt = stub_lat;
      end
    end
  end

  task automatic pix(int x, int y, logic [11:0] d);
    @(negedge clk);
    vga_ready = 1'b1; x_count = 10'(x); y_count = 9'(y); video_data = d;
    @(negedge clk);
    vga_ready = 1'b0;
  endtask

  task automatic wait_done(int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < budget);
    check("done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic send_frame(logic [11:0] l, logic [11:0] c, logic [11:0] r, logic [2:0] m);
    if (m[0]) pix(256, 240, l);
    if (m[1]) pix(320, 240, c);
    if (m[2]) pix(384, 240, r);
    pix(639, 479, 12'h000);
  endtask

  task automatic run_frame(string tag, logic [11:0] l, logic [11:0] c, logic [11:0] r,
                           logic [2:0] m, int exp_lat, logic [1:0] exp_code, logic exp_chg);
    int n;
    send_frame(l, c, r, m);
    wait_done(300, n);
    check({tag, "_latency"}, n + 1, exp_lat);
    check({tag, "_code"}, {30'd0, color_code}, {30'd0, exp_code});
    check({tag, "_changed"}, {31'd0, color_changed}, {31'd0, exp_chg});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_changed_pulse"}, {31'd0, color_changed}, 32'd0);
  endtask

  initial begin
    int n, i0, d0;
    reset = 1'b1; vga_ready = 1'b0; x_count = '0; y_count = '0; video_data = '0;
    repeat (3) @(negedge clk);
    check("rst_code", {30'd0, color_code}, 32'd0);
    check("rst_changed", {31'd0, color_changed}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, conv_timeout}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    check("rst_valid_in", {31'd0, hsv_valid_in}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    // Four red frames; the last uses red+green flags to exercise red priority.
    stub_lat = 1;
    run_frame("red1", 12'hF00, 12'hF00, 12'hF00, 3'b111, 8, 2'd0, 1'b0);
    run_frame("red2", 12'hF00, 12'hF00, 12'hF00, 3'b111, 8, 2'd0, 1'b0);
    run_frame("red3", 12'hF00, 12'hF00, 12'hF00, 3'b111, 8, 2'd0, 1'b0);
    run_frame("red4", 12'hFF0, 12'hFF0, 12'hFF0, 3'b111, 8, 2'd1, 1'b1);

    // Majority and NONE voting; four NONE frames clear the code.
    run_frame("rgr_hold", 12'hF00, 12'h0F0, 12'hF00, 3'b111, 8, 2'd1, 1'b0);
    run_frame("rgk_none", 12'hF00, 12'h0F0, 12'h000, 3'b111, 8, 2'd1, 1'b0);
    run_frame("empty1", 12'h000, 12'h000, 12'h000, 3'b000, 5, 2'd1, 1'b0);
    run_frame("empty2", 12'h000, 12'h000, 12'h000, 3'b000, 5, 2'd1, 1'b0);
    i0 = issue_cnt;
    run_frame("centre_only", 12'h000, 12'h0F0, 12'h000, 3'b010, 6, 2'd0, 1'b1);
    check("centre_only_issues", issue_cnt - i0, 1);
    run_frame("rgr1", 12'hF00, 12'h0F0, 12'hF00, 3'b111, 8, 2'd0, 1'b0);
    run_frame("rgr2", 12'hF00, 12'h0F0, 12'hF00, 3'b111, 8, 2'd0, 1'b0);
    run_frame("rgr3", 12'hF00, 12'h0F0, 12'hF00, 3'b111, 8, 2'd0, 1'b0);
    run_frame("rgr4", 12'hF00, 12'h0F0, 12'hF00, 3'b111, 8, 2'd1, 1'b1);

    // Converter never answers: timeout after exactly 32 WAIT cycles on probe 0.
    stub_lat = 0;
    send_frame(12'h0F0, 12'h0F0, 12'h0F0, 3'b111);
    repeat (32) @(negedge clk);
    check("tmo_not_yet", {31'd0, conv_timeout}, 32'd0);
    @(negedge clk);
    check("tmo_set", {31'd0, conv_timeout}, 32'd1);
    wait_done(300, n);
    check("tmo_latency", 33 + n + 1, 101);
    check("tmo_code_kept", {30'd0, color_code}, 32'd1);
    check("tmo_changed", {31'd0, color_changed}, 32'd0);
    @(negedge clk);
    check("tmo_idle", {31'd0, busy}, 32'd0);
    check("tmo_sticky", {31'd0, conv_timeout}, 32'd1);

    // Frame end while busy with a slow converter is dropped.
    stub_lat = 20;
    send_frame(12'hF00, 12'hF00, 12'hF00, 3'b111);
    pix(639, 479, 12'h000);
    check("drop_count", {24'd0, drop_count}, 32'd1);
    wait_done(300, n);
    check("slow_latency", 2 + n + 1, 65);
    #1 d0 = done_cnt;
    repeat (80) @(negedge clk);
    #1;
    check("no_extra_done", done_cnt, d0);
    check("drop_kept", {24'd0, drop_count}, 32'd1);
    check("slow_code", {30'd0, color_code}, 32'd1);

    // Reset during WAIT; the late converter answer must be ignored.
    stub_lat = 10;
    send_frame(12'hF00, 12'hF00, 12'hF00, 3'b111);
    repeat (3) @(negedge clk);
    check("pre_rst_wait", {30'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid_in", {31'd0, hsv_valid_in}, 32'd0);
    check("mid_rst_code", {30'd0, color_code}, 32'd0);
    check("mid_rst_timeout", {31'd0, conv_timeout}, 32'd0);
    check("mid_rst_drop", {24'd0, drop_count}, 32'd0);
    i0 = issue_cnt;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    #1;
    check("late_busy", {31'd0, busy}, 32'd0);
    check("late_no_done", done_cnt, d0);
    check("late_no_issue", issue_cnt, i0);
    check("late_code", {30'd0, color_code}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
